sr_latch_monitor: RTL
=====================

# sr_latch_monitor

Clocked observer for the cross-coupled NAND SR latch. It samples the latch's asynchronous inputs and outputs, tracks the latch state with a model, and flags forbidden input combinations and output mismatches. It counts set, reset and forbidden events. It sits beside the latch, as a self-check in benches and a health monitor in silicon.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles after an input-pair change before outputs are checked (range 1..255).
- CNT_W, default 8: width of each event counter.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert and active-low; deassertion is synchronised internally.
- clr  in  1  synchronous clear of counters and sticky error.
- S  in  1  latch set input, active-low, asynchronous to clk.
- R  in  1  latch reset input, active-low, asynchronous to clk.
- Q  in  1  latch output, asynchronous.
- notQ  in  1  latch complementary output, asynchronous.
- state  out  2  model state: 0 UNKNOWN, 1 SET, 2 RESET, 3 FORBIDDEN.
- err_forbidden  out  1  one-cycle pulse on entry to FORBIDDEN.
- err_mismatch  out  1  one-cycle pulse when a settled check fails.
- err_sticky  out  1  OR of all error pulses since reset or clr.
- set_cnt  out  CNT_W  count of entries to SET.
- rst_cnt  out  CNT_W  count of entries to RESET.
- forb_cnt  out  CNT_W  count of entries to FORBIDDEN.

## Operation
- Synchroniser: S, R, Q and notQ each pass through two flops. All logic uses the synchronised values (Ss, Rs, Qs, nQs).
- Expected latch behaviour:
  - S=0, R=1: Q=1, notQ=0.
  - S=1, R=0: Q=0, notQ=1.
  - S=1, R=1: hold.
  - S=0, R=0: Q=notQ=1 (forbidden).
- Target state from the synchronised pair {Ss,Rs}:
  - 01 gives SET.
  - 10 gives RESET.
  - 00 gives FORBIDDEN.
  - 11 keeps the current state, except from FORBIDDEN it goes to UNKNOWN (race outcome undefined).
- FSM: state updates one cycle after the synchronised pair changes.
  - Entry to SET increments set_cnt.
  - Entry to RESET increments rst_cnt.
  - Entry to FORBIDDEN increments forb_cnt and pulses err_forbidden.
  - A pair change that leaves the state unchanged (e.g. 01 then 11) does not count.
- Counters saturate at all-ones and never wrap.
- Settle counter: loaded with SETTLE_CYCLES on any change of {Ss,Rs} and decrements to 0. While it is nonzero, no check is made.
- Check, made every cycle while the settle counter is 0:
  - SET expects Qs=1, nQs=0.
  - RESET expects Qs=0, nQs=1.
  - FORBIDDEN expects Qs=1, nQs=1.
  - UNKNOWN expects only Qs != nQs.
  - A mismatch pulses err_mismatch once. It re-arms only after the next pair change, so one pulse is issued per settle window.
- clr: zeros all counters and err_sticky the next cycle. It does not alter state or the settle counter. When clr coincides with an increment, the clear wins.
- err_sticky sets on either pulse. If a pulse and clr arrive together, the pulse wins and err_sticky ends at 1.

## Timing
- Reset values: state=UNKNOWN, all counters 0, all error outputs 0, settle counter = SETTLE_CYCLES, synchroniser flops 1 (inputs idle).
- Reset mid-operation returns everything to these values immediately. The counters are lost.
- Input to state latency: 3 cycles (2 synchroniser plus 1 FSM register). Counters and err_forbidden update in the same cycle as state.
- Input change to first check: 2 + SETTLE_CYCLES + 1 cycles. The result appears as an err_mismatch pulse one cycle after the check cycle.
- Pair changes during the settle window reload the counter. Glitches shorter than SETTLE_CYCLES therefore never produce mismatch errors, but do produce state and counter activity.
- Q and notQ changes do not reload the settle counter.

## Test plan
- Reset then S=1, R=1 held: state=0, all counters 0, no errors over 20 cycles.
- S=0,R=1 with Q=1,notQ=0, then S=1,R=0 with Q=0,notQ=1, then S=1,R=1 (hold): set_cnt=1, rst_cnt=1, state=2, err_sticky=0.
- S=0,R=0 then S=1,R=1: err_forbidden pulses once at 3 cycles, forb_cnt=1, state then 0. With Q=notQ=0 while the latch is settled, err_mismatch pulses once.
- SET with Q stuck at 0: exactly one err_mismatch at 2+SETTLE_CYCLES+2 cycles, err_sticky=1, which clears only on clr.
- CNT_W=2, 5 SET/RESET toggles: set_cnt=3, rst_cnt=2. Continue toggling: both saturate at 3. Assert clr during an increment: counters read 0.
- Assert rst_n low mid-settle with counters nonzero: all outputs return to reset values asynchronously, and no error follows deassertion.

Source files
------------

// File: rtl/sr_latch_monitor_if.sv
// Signal bundle between an SR latch observer and whoever drives / watches it.
// master: drives the sampled latch pins and clr, reads results.
// slave:  the monitor itself.
interface sr_latch_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clr;
  logic             S;
  logic             R;
  logic             Q;
  logic             notQ;
  logic [1:0]       state;
  logic             err_forbidden;
  logic             err_mismatch;
  logic             err_sticky;
  logic [CNT_W-1:0] set_cnt;
  logic [CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0] forb_cnt;

  modport master (
    output clr, S, R, Q, notQ,
    input  state, err_forbidden, err_mismatch, err_sticky, set_cnt, rst_cnt, forb_cnt
  );

  modport slave (
    input  clr, S, R, Q, notQ,
    output state, err_forbidden, err_mismatch, err_sticky, set_cnt, rst_cnt, forb_cnt
  );
endinterface

// File: rtl/sr_latch_monitor.sv
// Clocked observer for a cross-coupled NAND SR latch. Synchronises the latch
// pins, models the expected latch state, flags forbidden inputs and output
// mismatches once the inputs have been stable long enough, and counts events.
module sr_latch_monitor #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic               clk,
  input logic               rst_n,
  sr_latch_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    StUnknown   = 2'd0,
    StSet       = 2'd1,
    StReset     = 2'd2,
    StForbidden = 2'd3
  } state_e;

  localparam logic [7:0]       SettleInit = 8'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  // Saturating event counter; clear beats increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic clr);
    if (clr) begin
      return '0;
    end else if (inc && (cnt != CntMax)) begin
      return cnt + CNT_W'(1);
    end
    return cnt;
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Reset asserts immediately, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Bit order within the synchroniser: {S, R, Q, notQ}.
  logic [3:0] meta_q, sync_q;
  logic       s_sync, r_sync, q_sync, nq_sync;
  logic [1:0] pair, pair_q;
  logic       pair_change;

  // Two-flop synchroniser; idle latch pins are high.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      meta_q <= '1;
      sync_q <= '1;
      pair_q <= 2'b11;
    end else begin
      meta_q <= {bus.S, bus.R, bus.Q, bus.notQ};
      sync_q <= meta_q;
      pair_q <= sync_q[3:2];
    end
  end

  assign s_sync      = sync_q[3];
  assign r_sync      = sync_q[2];
  assign q_sync      = sync_q[1];
  assign nq_sync     = sync_q[0];
  assign pair        = {s_sync, r_sync};
  assign pair_change = (pair != pair_q);

  state_e           state_q, state_d;
  logic [7:0]       settle_q, settle_d;
  logic             armed_q, armed_d;
  logic             check_bad;
  logic             set_entry, rst_entry, forb_entry;
  logic             mismatch_d;
  logic             err_forbidden_q, err_mismatch_q, err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] set_cnt_q, rst_cnt_q, forb_cnt_q;

  // Model next state from the synchronised input pair.
  always_comb begin
    state_d = state_q;
    unique case (pair)
      2'b01: state_d = StSet;
      2'b10: state_d = StReset;
      2'b00: state_d = StForbidden;
      2'b11: state_d = (state_q == StForbidden) ? StUnknown : state_q;
    endcase
  end

  // Entry detection, settle countdown and the settled output check.
  always_comb begin
    set_entry  = (state_d != state_q) && (state_d == StSet);
    rst_entry  = (state_d != state_q) && (state_d == StReset);
    forb_entry = (state_d != state_q) && (state_d == StForbidden);

    check_bad = 1'b0;
    unique case (state_q)
      StSet:       check_bad = !(q_sync && !nq_sync);
      StReset:     check_bad = !(!q_sync && nq_sync);
      StForbidden: check_bad = !(q_sync && nq_sync);
      StUnknown:   check_bad = (q_sync == nq_sync);
    endcase

    // A pair change in this cycle means the state register is still stale,
    // so the check is withheld as if the settle counter were already loaded.
    mismatch_d = armed_q && (settle_q == 8'd0) && !pair_change && check_bad;

    settle_d = settle_q;
    if (pair_change)            settle_d = SettleInit;
    else if (settle_q != 8'd0)  settle_d = settle_q - 8'd1;

    armed_d = armed_q;
    if (pair_change)     armed_d = 1'b1;
    else if (mismatch_d) armed_d = 1'b0;

    // A pulse coinciding with clr still leaves the sticky flag set.
    err_sticky_d = (err_sticky_q && !bus.clr) || forb_entry || mismatch_d;
  end

  // State, settle and error registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q         <= StUnknown;
      settle_q        <= SettleInit;
      armed_q         <= 1'b1;
      err_forbidden_q <= 1'b0;
      err_mismatch_q  <= 1'b0;
      err_sticky_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      settle_q        <= settle_d;
      armed_q         <= armed_d;
      err_forbidden_q <= forb_entry;
      err_mismatch_q  <= mismatch_d;
      err_sticky_q    <= err_sticky_d;
    end
  end

  // Event counters.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      set_cnt_q  <= '0;
      rst_cnt_q  <= '0;
      forb_cnt_q <= '0;
    end else begin
      set_cnt_q  <= cnt_next(set_cnt_q, set_entry, bus.clr);
      rst_cnt_q  <= cnt_next(rst_cnt_q, rst_entry, bus.clr);
      forb_cnt_q <= cnt_next(forb_cnt_q, forb_entry, bus.clr);
    end
  end

  assign bus.state         = state_q;
  assign bus.err_forbidden = err_forbidden_q;
  assign bus.err_mismatch  = err_mismatch_q;
  assign bus.err_sticky    = err_sticky_q;
  assign bus.set_cnt       = set_cnt_q;
  assign bus.rst_cnt       = rst_cnt_q;
  assign bus.forb_cnt      = forb_cnt_q;

endmodule
